// File: rtl/numpad_decoder_if.sv
// Event/token bus between the numpad scanner, the decoder and the calculator core.
// The master side drives scanner events and consumer handshakes; the slave side is the decoder.
interface numpad_decoder_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [5:0]    value;
  logic [4:0]    token;
  logic          token_valid;
  logic          token_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clear_overflow;

  modport master (
    output value,
    output token_ready,
    output clear_overflow,
    input  token,
    input  token_valid,
    input  count,
    input  overflow
  );

  modport slave (
    input  value,
    input  token_ready,
    input  clear_overflow,
    output token,
    output token_valid,
    output count,
    output overflow
  );
endinterface

// File: rtl/numpad_decoder.sv
// numpad_decoder: turns scanner press events into 5-bit calculator tokens
// {kind, code} and buffers them in a show-ahead circular FIFO with a
// valid/ready output handshake and a sticky overflow flag.
module numpad_decoder #(
  parameter int DEPTH = 4
) (
  input logic              clock,
  input logic              reset_n,
  numpad_decoder_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Main-keyboard key labels come from the physical column/row layout;
  // alternative-keyboard codes pass through untouched with kind=1.
  function automatic logic [4:0] decode_event(input logic main_kb, input logic [3:0] btn);
    logic [3:0] label;
    case (btn)
      4'd0:    label = 4'h1;
      4'd1:    label = 4'h4;
      4'd2:    label = 4'h7;
      4'd3:    label = 4'h0;
      4'd4:    label = 4'h2;
      4'd5:    label = 4'h5;
      4'd6:    label = 4'h8;
      4'd7:    label = 4'hF;
      4'd8:    label = 4'h3;
      4'd9:    label = 4'h6;
      4'd10:   label = 4'h9;
      4'd11:   label = 4'hE;
      4'd12:   label = 4'hA;
      4'd13:   label = 4'hB;
      4'd14:   label = 4'hC;
      4'd15:   label = 4'hD;
      default: label = 4'h0;
    endcase
    if (main_kb) begin
      return {1'b0, label};
    end else begin
      return {1'b1, btn};
    end
  endfunction

  logic [4:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic          accept_s;
  logic          drop_s;
  logic [4:0]    tok_s;

  // Handshake qualifiers: a full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    push_s   = bus.value[5];
    empty_s  = (count_q == {CW{1'b0}});
    full_s   = (count_q == CW'(DEPTH));
    pop_s    = !empty_s && bus.token_ready;
    accept_s = push_s && (!full_s || pop_s);
    drop_s   = push_s && full_s && !pop_s;
    tok_s    = decode_event(bus.value[4], bus.value[3:0]);
  end

  // Next-state for pointers, occupancy and the sticky overflow flag (a drop beats a clear).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (accept_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !accept_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end

    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state registers; reset takes effect immediately, mid-cycle included.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Token storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clock) begin
    if (accept_s) begin
      mem_q[wr_ptr_q] <= tok_s;
    end
  end

  // Show-ahead head token, forced to zero whenever the FIFO is empty.
  always_comb begin
    bus.token_valid = !empty_s;
    bus.count       = count_q;
    bus.overflow    = overflow_q;
    if (!empty_s) begin
      bus.token = mem_q[rd_ptr_q];
    end else begin
      bus.token = 5'd0;
    end
  end

endmodule

// File: tb/tb_numpad_decoder.sv
// Scoreboard bench for numpad_decoder: stimulus pushes hand-computed tokens,
// a negedge monitor pops and compares every handshake completed by the DUT.
module tb_numpad_decoder;

  localparam int DEPTH = 4;

  logic clock;
  logic reset_n;

  numpad_decoder_if #(.DEPTH(DEPTH)) bus ();

  numpad_decoder #(.DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [4:0] sb [$];

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One-cycle event pulse; exp_tok is queued only when the push should be accepted.
  task automatic ev(input logic [5:0] v, input logic [4:0] exp_tok, input bit accepted);
    bus.value = v;
    if (accepted) sb.push_back(exp_tok);
    tick();
    bus.value = 6'd0;
  endtask

  // Monitor: a handshake seen here completes on the next rising edge.
  always @(negedge clock) begin
    if (reset_n && bus.token_valid && bus.token_ready) begin
      n_vec = n_vec + 1;
      if (sb.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL pop_unexpected: got token %h, expected no token", bus.token);
      end else begin
        logic [4:0] exp_tok;
        exp_tok = sb.pop_front();
        if (bus.token !== exp_tok) begin
          n_err = n_err + 1;
          $display("FAIL pop_token: got %h, expected %h", bus.token, exp_tok);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n            = 1'b0;
    bus.value          = 6'd0;
    bus.token_ready    = 1'b0;
    bus.clear_overflow = 1'b0;
    tick();
    tick();
    chk("rst_count", 8'(bus.count), 8'd0);
    chk("rst_valid", 8'(bus.token_valid), 8'd0);
    chk("rst_token", 8'(bus.token), 8'd0);
    chk("rst_ovf", 8'(bus.overflow), 8'd0);
    reset_n = 1'b1;
    tick();

    // Main-keyboard decode, held with ready low
    ev(6'b110111, 5'h0F, 1'b1);
    chk("main_tok7", 8'(bus.token), 8'h0F);
    chk("main_cnt1", 8'(bus.count), 8'd1);
    chk("main_valid", 8'(bus.token_valid), 8'd1);
    ev(6'b110011, 5'h00, 1'b1);
    chk("main_cnt2", 8'(bus.count), 8'd2);
    chk("main_head", 8'(bus.token), 8'h0F);

    // Alternative keyboard and a non-event cycle
    ev(6'b101101, 5'h1D, 1'b1);
    chk("alt_cnt3", 8'(bus.count), 8'd3);
    ev(6'b001101, 5'h00, 1'b0);
    chk("noevt_cnt", 8'(bus.count), 8'd3);

    // Fill to DEPTH, then a dropped 5th event
    ev(6'b111100, 5'h0A, 1'b1);
    chk("full_cnt", 8'(bus.count), 8'd4);
    chk("full_ovf0", 8'(bus.overflow), 8'd0);
    ev(6'b110000, 5'h01, 1'b0);
    chk("drop_cnt", 8'(bus.count), 8'd4);
    chk("drop_ovf", 8'(bus.overflow), 8'd1);

    // Push and pop together while full
    bus.token_ready = 1'b1;
    ev(6'b110101, 5'h05, 1'b1);
    bus.token_ready = 1'b0;
    chk("pp_full_cnt", 8'(bus.count), 8'd4);
    chk("pp_full_ovf", 8'(bus.overflow), 8'd1);
    chk("pp_full_head", 8'(bus.token), 8'h00);

    // Clear alone, then clear colliding with a drop
    bus.clear_overflow = 1'b1;
    tick();
    bus.clear_overflow = 1'b0;
    chk("clr_ovf", 8'(bus.overflow), 8'd0);
    bus.clear_overflow = 1'b1;
    ev(6'b111111, 5'h0D, 1'b0);
    bus.clear_overflow = 1'b0;
    chk("clr_drop_ovf", 8'(bus.overflow), 8'd1);
    chk("clr_drop_cnt", 8'(bus.count), 8'd4);

    // Drain: order 00,1D,0A,05 is checked by the monitor
    bus.token_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.count == 3'd0) break;
      tick();
    end
    chk("drain_cnt", 8'(bus.count), 8'd0);
    chk("drain_valid", 8'(bus.token_valid), 8'd0);
    chk("drain_token", 8'(bus.token), 8'd0);
    chk("drain_sb_left", 8'(sb.size()), 8'd0);

    // Throughput: back-to-back events with ready held high
    begin
      logic [5:0] tv [6];
      logic [4:0] tt [6];
      tv = '{6'b110001, 6'b110010, 6'b110110, 6'b111001, 6'b111101, 6'b100110};
      tt = '{5'h04,     5'h07,     5'h08,     5'h06,     5'h0B,     5'h16};
      for (int i = 0; i < 6; i++) begin
        ev(tv[i], tt[i], 1'b1);
        chk("tput_cnt", 8'(bus.count), 8'd1);
        chk("tput_head", 8'(bus.token), 8'(tt[i]));
      end
      tick();
      chk("tput_end_cnt", 8'(bus.count), 8'd0);
      chk("tput_sb_left", 8'(sb.size()), 8'd0);
    end

    // Asynchronous reset mid-stream with two tokens queued and overflow set
    bus.token_ready = 1'b0;
    ev(6'b110000, 5'h01, 1'b1);
    ev(6'b110100, 5'h02, 1'b1);
    chk("pre_rst_cnt", 8'(bus.count), 8'd2);
    chk("pre_rst_ovf", 8'(bus.overflow), 8'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_cnt", 8'(bus.count), 8'd0);
    chk("async_rst_valid", 8'(bus.token_valid), 8'd0);
    chk("async_rst_token", 8'(bus.token), 8'd0);
    chk("async_rst_ovf", 8'(bus.overflow), 8'd0);
    sb.delete();
    tick();
    reset_n = 1'b1;
    tick();
    ev(6'b100000, 5'h10, 1'b1);
    chk("post_rst_tok", 8'(bus.token), 8'h10);
    chk("post_rst_cnt", 8'(bus.count), 8'd1);
    bus.token_ready = 1'b1;
    tick();
    bus.token_ready = 1'b0;
    chk("post_rst_drain", 8'(bus.count), 8'd0);
    chk("final_sb_left", 8'(sb.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/numpad_decoder.md
# numpad_decoder

Consumer side of the numpad scanner's 6-bit change-event bus. It decodes each key-press event into a 5-bit calculator token: a hex digit on the main keyboard, or a raw command code on the alternative keyboard. Tokens are buffered in a small show-ahead FIFO and handed to the calculator core over a valid/ready handshake. It sits between the numpad scanner and the calculator's input/state logic.

## Interface
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two, ≥2.
- `clock`  input  1: system clock, 50 MHz.
- `reset_n`  input  1: asynchronous, active-low reset.
- `value`  input  6: scanner event `{is_changed, keyboard, btn[3:0]}`.
  - `value[5]`=1 marks a one-cycle press event.
  - `value[4]`=1 is the main keyboard, 0 is the alternative keyboard.
  - `btn` = `{col[1:0], row[1:0]}`.
- `token`  output  5: head-of-FIFO token `{kind, code[3:0]}`. Forced to 0 when the FIFO is empty.
- `token_valid`  output  1: FIFO is not empty.
- `token_ready`  input  1: consumer accepts the head token.
- `count`  output  log2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `overflow`  output  1: sticky flag; at least one event was dropped because the FIFO was full.
- `clear_overflow`  input  1: synchronous clear for `overflow`.

## Operation
- **Event detection:** a push is requested in every cycle with `value[5]`=1. `value[5]`=0 cycles are ignored, whatever the lower bits hold. The scanner never reports releases, so there is no release handling.
- **Decode for the main keyboard** (`value[4]`=1): `kind`=0 and `code` = the key label, looked up from `btn`:
  - btn 0,1,2,3 → 1, 4, 7, 0
  - btn 4,5,6,7 → 2, 5, 8, F
  - btn 8,9,10,11 → 3, 6, 9, E
  - btn 12,13,14,15 → A, B, C, D
- **Decode for the alternative keyboard** (`value[4]`=0): `kind`=1 and `code` = `btn` unchanged. The calculator core assigns operator meaning to these codes.
- **FIFO:** circular buffer with write and read pointers that wrap modulo DEPTH.
  - Push writes the decoded token at the write pointer.
  - Pop happens when `token_valid` && `token_ready`. It advances the read pointer.
  - Show-ahead: `token` = mem[rd_ptr] combinationally while `count`>0.
- **Boundary rules:**
  - Push with `count`<DEPTH: accepted.
  - Push with `count`=DEPTH and no pop in the same cycle: token dropped; `overflow` set; pointers and `count` unchanged.
  - Push and pop in the same cycle with the FIFO full: both happen; `count` stays DEPTH; no overflow.
  - Push and pop in the same cycle with the FIFO non-empty and not full: both happen; `count` unchanged.
  - Pop with `count`=0 is impossible, because `token_valid`=0. `token_ready` is don't-care when empty.
  - `clear_overflow` and a drop in the same cycle: set wins, so `overflow`=1.
- **Reset** (`reset_n`=0, asynchronous, effective mid-operation): pointers=0, `count`=0, `token_valid`=0, `token`=0, `overflow`=0. FIFO contents are don't-care. An event present during reset is lost.

## Timing
- **Latency:** an event sampled at edge N into an empty FIFO gives `token_valid`=1 with the decoded token after edge N (one cycle).
- **Back-to-back:** events arriving in consecutive cycles are all accepted up to DEPTH. The scanner's real event rate is at most one per 2048 cycles.
- **Throughput:** with `token_ready` held at 1, one token is consumed per cycle.
- **Handshake:** `token` and `token_valid` change only after a clock edge, never combinationally from `token_ready`.
- **Output updates:**
  - `count` updates on the same edge as the push or pop.
  - `overflow` sets on the edge that sampled the dropped event.
  - `overflow` clears on the edge after `clear_overflow`=1, unless a drop occurs on that same edge.

## Test plan
- **Reset values:** assert `reset_n`=0 mid-stream with 2 tokens queued → `count`=0, `token_valid`=0, `token`=0, `overflow`=0 immediately, without waiting for a clock edge.
- **Main-keyboard decode:** `value`=6'b110111, hold `token_ready`=0 → next cycle `token`=5'h0F, `count`=1. Then `value`=6'b110011 → second entry 5'h00; head is still 5'h0F.
- **Alternative-keyboard decode:** `value`=6'b101101 → `token`=5'h1D. `value`=6'b001101 (no `value[5]`) → no push, `count` unchanged.
- **Full FIFO, DEPTH=4:** push 5 events with `token_ready`=0 → `count`=4 and `overflow`=1, and the 5th token is absent when the FIFO is drained. Then push and pop in the same cycle while full → `count`=4, new token lands at the tail, `overflow` unchanged.
- **Overflow clear:** pulse `clear_overflow` alone → `overflow`=0. Pulse `clear_overflow` in the same cycle as a dropped push → `overflow` stays 1.
- **Throughput and ordering:** push 6 events with `token_ready`=1 → tokens emerge in order, one per cycle, and `count` never exceeds 1.
